// File: rtl/ir_pkg.sv
// Shared widths, field positions and the decoded-field struct for the instruction queue/register.
package ir_pkg;

    localparam int FIELD_W = 4;
    localparam int NBIT    = 4 * FIELD_W;

    localparam int OPC_MSB = NBIT - 1;
    localparam int DA_MSB  = NBIT - FIELD_W - 1;
    localparam int AA_MSB  = NBIT - 2 * FIELD_W - 1;
    localparam int BA_MSB  = FIELD_W - 1;

    typedef struct packed {
        logic [FIELD_W-1:0] opcode;
        logic [FIELD_W-1:0] da;
        logic [FIELD_W-1:0] aa;
        logic [FIELD_W-1:0] ba;
    } ir_fields_t;

    function automatic ir_fields_t split_fields(input logic [NBIT-1:0] word);
        ir_fields_t f;
        f.opcode = word[OPC_MSB -: FIELD_W];
        f.da     = word[DA_MSB  -: FIELD_W];
        f.aa     = word[AA_MSB  -: FIELD_W];
        f.ba     = word[BA_MSB  -: FIELD_W];
        return f;
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Circular instruction buffer with wrap-bit pointers; state changes on the falling clock edge.
module ir_fifo
    import ir_pkg::*;
#(
    parameter int NBIT  = ir_pkg::NBIT,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [NBIT-1:0]          i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [NBIT-1:0]          o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [NBIT-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Equal indices with differing wrap bits means the writer lapped the reader.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // Pointer update: flush rewinds both, otherwise push/pop advance independently.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

    // Storage write at the tail slot.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end else begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/instr_queue_reg.sv
// Instruction queue feeding a holding register that presents opcode/DA/AA/BA to the control unit.
// Optional flush port and behaviour enabled by defining IR_FLUSH_EN.
module instr_queue_reg
    import ir_pkg::*;
#(
    parameter int NBIT  = ir_pkg::NBIT,
    parameter int FIELD = ir_pkg::FIELD_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NBIT-1:0]          instr_in,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     advance,
    output logic [FIELD-1:0]         opcode,
    output logic [FIELD-1:0]         DA,
    output logic [FIELD-1:0]         AA,
    output logic [FIELD-1:0]         BA,
    output logic                     ir_valid,
    output logic [$clog2(DEPTH)+1:0] occupancy
`ifdef IR_FLUSH_EN
    ,
    input  logic                     flush
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(DEPTH) + 2;

    logic [NBIT-1:0] r_ir;
    logic            r_ir_valid;
    logic [NBIT-1:0] w_q_rdata;
    logic            w_q_full;
    logic            w_q_empty;
    logic [CW-1:0]   w_q_count;
    logic            w_flush;
    logic            w_push;
    logic            w_ir_empty_next;
    logic            w_load_head;
    logic            w_bypass;
    logic            w_q_push;

`ifdef IR_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Ready deliberately ignores a same-edge pop so it depends only on registered state.
    assign instr_ready     = !w_q_full && !w_flush;
    assign w_push          = instr_valid && instr_ready;
    assign w_ir_empty_next = !r_ir_valid || advance;
    assign w_load_head     = w_ir_empty_next && !w_q_empty && !w_flush;
    assign w_bypass        = w_ir_empty_next && w_q_empty && w_push;
    assign w_q_push        = w_push && !w_bypass;

    ir_fifo #(
        .NBIT  (NBIT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_q_push),
        .i_wdata (instr_in),
        .i_pop   (w_load_head),
        .i_flush (w_flush),
        .o_rdata (w_q_rdata),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

    // Holding register: queue head first, bypass when queue empty, fields held when drained.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_flush) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_ir_empty_next) begin
            if (!w_q_empty) begin
                r_ir       <= w_q_rdata;
                r_ir_valid <= 1'b1;
            end else if (w_push) begin
                r_ir       <= instr_in;
                r_ir_valid <= 1'b1;
            end else begin
                r_ir       <= r_ir;
                r_ir_valid <= 1'b0;
            end
        end else begin
            r_ir       <= r_ir;
            r_ir_valid <= r_ir_valid;
        end
    end

    assign opcode    = r_ir[NBIT-1         -: FIELD];
    assign DA        = r_ir[NBIT-FIELD-1   -: FIELD];
    assign AA        = r_ir[NBIT-2*FIELD-1 -: FIELD];
    assign BA        = r_ir[FIELD-1:0];
    assign ir_valid  = r_ir_valid;
    assign occupancy = OW'(w_q_count) + OW'(r_ir_valid);

endmodule

// File: tb/tb_instr_queue_reg.sv
// Directed plus random bench for instr_queue_reg against a queue-based reference model.
module tb_instr_queue_reg;
    import ir_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        advance;
    logic [3:0]  opcode;
    logic [3:0]  DA;
    logic [3:0]  AA;
    logic [3:0]  BA;
    logic        ir_valid;
    logic [3:0]  occupancy;
    logic        flush_s;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_q[$];
    logic [15:0] m_ir;
    logic        m_valid;

    instr_queue_reg #(.NBIT(16), .FIELD(4), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .advance     (advance),
        .opcode      (opcode),
        .DA          (DA),
        .AA          (AA),
        .BA          (BA),
        .ir_valid    (ir_valid),
        .occupancy   (occupancy)
`ifdef IR_FLUSH_EN
        ,
        .flush       (flush_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input bit f);
        return (m_q.size() < DEPTH) && !f;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ir    = 16'h0000;
        m_valid = 1'b0;
    endtask

    // Reference behaviour at one falling edge.
    task automatic model_edge(input bit v, input logic [15:0] d, input bit a, input bit f);
        bit push;
        push = v && model_ready(f);
        if (f) begin
            model_reset();
        end else if (!m_valid || a) begin
            if (m_q.size() > 0) begin
                m_ir    = m_q.pop_front();
                m_valid = 1'b1;
                if (push) m_q.push_back(d);
            end else if (push) begin
                m_ir    = d;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else if (push) begin
            m_q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        ir_fields_t f;
        f = split_fields(m_ir);
        chk({tag, ".opcode"}, 32'(opcode), 32'(f.opcode));
        chk({tag, ".DA"}, 32'(DA), 32'(f.da));
        chk({tag, ".AA"}, 32'(AA), 32'(f.aa));
        chk({tag, ".BA"}, 32'(BA), 32'(f.ba));
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(m_q.size() + int'(m_valid)));
    endtask

    // One cycle: drive inputs, check ready before the edge, then all outputs after it.
    task automatic cyc(input string tag, input bit v, input logic [15:0] d, input bit a, input bit f);
        instr_valid = v;
        instr_in    = d;
        advance     = a;
        flush_s     = f;
        #1;
        chk({tag, ".instr_ready"}, 32'(instr_ready), 32'(model_ready(f)));
        @(negedge clk);
        model_edge(v, d, a, f);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        instr_in = 16'h0000;
        instr_valid = 1'b0;
        advance = 1'b0;
        flush_s = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check_all("reset");
        chk("reset.instr_ready", 32'(instr_ready), 32'd1);
        reset = 1'b0;

        // Single word into idle block
        cyc("t1", 1'b1, 16'hA123, 1'b0, 1'b0);
        chk("t1.opc_const", 32'(opcode), 32'hA);
        chk("t1.ba_const", 32'(BA), 32'h3);
        cyc("t1.drain", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill to full, then an extra push is refused
        for (int i = 1; i <= 6; i++) begin
            cyc("t2", 1'b1, 16'(i * 16'h1111), 1'b0, 1'b0);
        end
        chk("t2.occ_const", 32'(occupancy), 32'd5);
        chk("t2.ready_full", 32'(instr_ready), 32'd0);

        // Drain by advances
        for (int i = 0; i < 5; i++) begin
            cyc("t3", 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("t3.fields_hold", {16'h0, opcode, DA, AA, BA}, 32'h5555);
        chk("t3.valid_low", 32'(ir_valid), 32'd0);

        // Streaming, one push and one advance every cycle
        for (int i = 0; i < 12; i++) begin
            cyc("t4", 1'b1, 16'(i), 1'b1, 1'b0);
            chk("t4.occ_const", 32'(occupancy), 32'd1);
        end
        cyc("t4.drain", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset between edges
        for (int i = 0; i < 4; i++) begin
            cyc("t5.fill", 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
        end
        instr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t5.async");
        #1;
        reset = 1'b0;
        cyc("t5.after", 1'b1, 16'h7E57, 1'b0, 1'b0);
        chk("t5.after_valid", 32'(ir_valid), 32'd1);

`ifdef IR_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            cyc("t6.fill", 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
        end
        cyc("t6.flush", 1'b1, 16'hBEEF, 1'b1, 1'b1);
        chk("t6.occ_zero", 32'(occupancy), 32'd0);
        chk("t6.fields_zero", {16'h0, opcode, DA, AA, BA}, 32'h0);
        cyc("t6.after", 1'b0, 16'h0000, 1'b1, 1'b0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit f;
            f = 1'b0;
`ifdef IR_FLUSH_EN
            f = ($urandom_range(0, 19) == 0);
`endif
            cyc("rnd", 1'($urandom_range(0, 1)), 16'($urandom),
                ($urandom_range(0, 2) == 0), f);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
